reset_sequencer: RTL

- Parametrised successor to the single-output boot reset generator in the FPGA top.
- Drives NUM_DOMAINS active-low reset outputs (e.g. processor core, memory, UART/SPI controller, peripherals) and releases them in staged order after a power-on hold.
- Qualifies the board reset button through a synchroniser and debouncer.
- Accepts a masked software reset request from the controller, so selected domains can be re-reset without a full reboot.

---
 rtl/processorci_reset_pkg.sv | 19 +
 rtl/reset_synchronizer.sv | 25 ++
 rtl/reset_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/processorci_reset_pkg.sv
// Shared types and constants for the staged reset sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package processorci_reset_pkg;

  // Sequencer states: power-on/after-button hold, staged release, idle, button held.
  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RELEASE  = 2'd1,
    RUN      = 2'd2,
    EXT_WAIT = 2'd3
  } seq_state_t;

  // Encoding of the last reset source reported on reset_cause_o.
  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_EXT = 2'b10;
  localparam logic [1:0] CAUSE_SW  = 2'b11;

endpackage

// File: rtl/reset_synchronizer.sv
// Async-assert / sync-deassert reset conditioner (flop chain).
// Latency: STAGES clk edges from async_rst_n rising to sync_rst_n rising; assertion is immediate.
// Backpressure: none.
module reset_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic async_rst_n,
  output logic sync_rst_n
);

  logic [STAGES-1:0] chain;

  // Clear the whole chain the moment reset asserts; shift ones in once it lifts.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged multi-domain reset generator with debounced button and masked software reset.
// Latency: POR release of domain k at edge SYNC_STAGES+HOLD_CYCLES+k*STAGE_GAP; outputs registered.
// Backpressure: none; sw_rst_i outside RUN or with an empty mask is dropped.
module reset_sequencer
  import processorci_reset_pkg::*;
#(
  parameter int NUM_DOMAINS     = 4,
  parameter int HOLD_CYCLES     = 20,
  parameter int STAGE_GAP       = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ext_rst_i,
  input  logic                   sw_rst_i,
  input  logic [NUM_DOMAINS-1:0] domain_mask_i,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   busy_o,
  output logic                   all_released_o,
  output logic [1:0]             reset_cause_o
);

  // The hold and gap phases share one counter, so it is sized for the larger of the two.
  localparam int SEQ_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int SEQ_W   = $clog2(SEQ_MAX) + 1;
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(HOLD_CYCLES - 1);
  localparam logic [SEQ_W-1:0] GAP_LAST  = SEQ_W'(STAGE_GAP - 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_DONE  = DEB_W'(DEBOUNCE_CYCLES);

  // Parameter sanity, caught at elaboration.
  if (NUM_DOMAINS < 1) begin : g_chk_domains
    $error("reset_sequencer: NUM_DOMAINS must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_chk_gap
    $error("reset_sequencer: STAGE_GAP must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
    $error("reset_sequencer: DEBOUNCE_CYCLES must be >= 1");
  end

  logic                   sys_rst_n;
  logic [SYNC_STAGES-1:0] ext_ff;
  logic                   ext_sync;
  logic [DEB_W-1:0]       deb_cnt;
  logic                   ext_qual;

  seq_state_t             state, state_nxt;
  logic [SEQ_W-1:0]       cnt, cnt_nxt;
  logic [NUM_DOMAINS-1:0] pend, pend_nxt;
  logic [NUM_DOMAINS-1:0] next_bit;
  logic [NUM_DOMAINS-1:0] rst_nxt;
  logic [1:0]             cause_nxt;
  logic                   busy_nxt;
  logic                   all_nxt;

  // Board reset: asserts everything at once, lifts cleanly on a clock edge.
  reset_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_por_sync (
    .clk        (clk),
    .async_rst_n(rst_n),
    .sync_rst_n (sys_rst_n)
  );

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ext_ff <= '0;
    end else begin
      ext_ff <= {ext_ff[SYNC_STAGES-2:0], ext_rst_i};
    end
  end

  assign ext_sync = ext_ff[SYNC_STAGES-1];

  // Count consecutive high samples of the button; any low sample starts over, top value sticks.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      deb_cnt <= '0;
    end else if (!ext_sync) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DEB_DONE) begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // The press is accepted on exactly the edge the counter reaches its terminal value,
  // so a button held down afterwards does not re-trigger.
  assign ext_qual = ext_sync && (deb_cnt == DEB_LAST);

  // Lowest-index domain still waiting to come out of reset.
  assign next_bit = pend & (~pend + NUM_DOMAINS'(1));

  // Next-state and next-output decisions; a qualified button press overrides everything else.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    rst_nxt   = rst_n_o;
    cause_nxt = reset_cause_o;

    if (ext_qual) begin
      state_nxt = EXT_WAIT;
      cnt_nxt   = '0;
      pend_nxt  = '0;
      rst_nxt   = '0;
      cause_nxt = CAUSE_EXT;
    end else begin
      unique case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_nxt   = rst_n_o | next_bit;
            pend_nxt  = pend & ~next_bit;
            cnt_nxt   = '0;
            state_nxt = (pend_nxt == '0) ? RUN : RELEASE;
          end else begin
            cnt_nxt = cnt + SEQ_W'(1);
          end
        end
        RELEASE: begin
          if (cnt == GAP_LAST) begin
            rst_nxt   = rst_n_o | next_bit;
            pend_nxt  = pend & ~next_bit;
            cnt_nxt   = '0;
            state_nxt = (pend_nxt == '0) ? RUN : RELEASE;
          end else begin
            cnt_nxt = cnt + SEQ_W'(1);
          end
        end
        RUN: begin
          // Only masked domains are pulled low and queued; the rest keep running.
          if (sw_rst_i && (domain_mask_i != '0)) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            pend_nxt  = domain_mask_i;
            rst_nxt   = rst_n_o & ~domain_mask_i;
            cause_nxt = CAUSE_SW;
          end
        end
        EXT_WAIT: begin
          // Button let go: replay the full power-on release of every domain.
          if (!ext_sync) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            pend_nxt  = '1;
          end
        end
        default: begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          pend_nxt  = '1;
          rst_nxt   = '0;
        end
      endcase
    end

    busy_nxt = (state_nxt != RUN);
    all_nxt  = &rst_nxt;
  end

  // Sequencer state and registered outputs; reset puts every domain in reset under POR cause.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= HOLD;
      cnt            <= '0;
      pend           <= '1;
      rst_n_o        <= '0;
      busy_o         <= 1'b1;
      all_released_o <= 1'b0;
      reset_cause_o  <= CAUSE_POR;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      pend           <= pend_nxt;
      rst_n_o        <= rst_nxt;
      busy_o         <= busy_nxt;
      all_released_o <= all_nxt;
      reset_cause_o  <= cause_nxt;
    end
  end

endmodule
